// File: rtl/cache_controller.sv
// cache_controller: snooping MSI controller, 2-line direct-mapped, 4-bit words.
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
// Ports: clk, rst_n (async low); req/we/addr/wdata -> rdata/done (processor);
//   bus_req/bus_grant/bus_out (own messages); snoop (others' traffic);
//   mem_q (fill data from shared memory).
module cache_controller #(
  parameter logic [1:0] ReadMiss  = 2'b01,
  parameter logic [1:0] WriteMiss = 2'b10,
  parameter logic [1:0] WriteBack = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [3:0] wdata,
  output logic [3:0] rdata,
  output logic       done,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] bus_out,
  input  logic [7:0] snoop,
  input  logic [3:0] mem_q
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
`endif
);

  typedef enum logic [1:0] {LI, LS, LM} line_t;
  typedef enum logic [2:0] {
    IDLE, VICTIM_WB, MISS_REQ, FILL1, FILL2
  } fsm_t;

  fsm_t       st, nst;
  line_t      lst  [2];
  logic [1:0] ltag;
  logic [3:0] ldat [2];

  logic       r_we;
  logic [1:0] r_addr;
  logic [3:0] r_wdata;

  logic       iidx, ridx, sidx;
  logic       hit, vic, shit, interv, gnt;
  logic [3:0] fill;

  assign iidx = addr[0];
  assign ridx = r_addr[0];
  assign sidx = snoop[4];

  assign hit = (ltag[iidx] == addr[1]) &&
               (we ? (lst[iidx] == LM)
                   : (lst[iidx] != LI));
  assign vic = (lst[iidx] == LM) &&
               (ltag[iidx] != addr[1]);

  assign shit = (lst[sidx] != LI) &&
                (ltag[sidx] == snoop[5]);
  // Supplying dirty data outranks our own granted message.
  assign interv = shit && (lst[sidx] == LM) &&
                  (snoop[7:6] == ReadMiss ||
                   snoop[7:6] == WriteMiss);
  assign gnt = bus_req && bus_grant && !interv;

  // A write-back of our address in the slot wins over memory.
  assign fill = (snoop[7:6] == WriteBack &&
                 snoop[5:4] == r_addr) ? snoop[3:0]
                                       : mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:
        if (req) begin
          unique case (1'b1)
            hit:     nst = IDLE;
            vic:     nst = VICTIM_WB;
            default: nst = MISS_REQ;
          endcase
        end
      VICTIM_WB:
        if (gnt) nst = MISS_REQ;
      MISS_REQ:
        if (gnt) nst = r_we ? IDLE : FILL1;
      FILL1:   nst = FILL2;
      FILL2:   nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        lst[i]  <= LI;
        ldat[i] <= '0;
      end
      ltag    <= '0;
      bus_out <= '0;
      rdata   <= '0;
      done    <= 1'b0;
      bus_req <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      bus_out <= 8'h00;
      done    <= 1'b0;
      if (shit) begin
        if (snoop[7:6] == ReadMiss &&
            lst[sidx] == LM)
          lst[sidx] <= LS;
        else if (snoop[7:6] == WriteMiss)
          lst[sidx] <= LI;
      end
      if (interv)
        bus_out <= {WriteBack, snoop[5:4],
                    ldat[sidx]};
      unique case (st)
        IDLE:
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (hit) begin
              done <= 1'b1;
              if (we) ldat[iidx] <= wdata;
              else    rdata      <= ldat[iidx];
            end else begin
              bus_req <= 1'b1;
            end
          end
        VICTIM_WB:
          if (gnt) begin
            bus_req <= 1'b0;
            // A snoop may have downgraded the victim already.
            if (lst[ridx] == LM) begin
              bus_out <= {WriteBack, ltag[ridx],
                          ridx, ldat[ridx]};
              lst[ridx] <= LI;
            end
          end else begin
            bus_req <= 1'b1;
          end
        MISS_REQ:
          if (gnt) begin
            bus_req <= 1'b0;
            if (r_we) begin
              bus_out <= {WriteMiss, r_addr, r_wdata};
              lst[ridx]  <= LM;
              ltag[ridx] <= r_addr[1];
              ldat[ridx] <= r_wdata;
              done       <= 1'b1;
            end else begin
              bus_out <= {ReadMiss, r_addr, 4'b0000};
            end
          end else begin
            bus_req <= 1'b1;
          end
        FILL2: begin
          lst[ridx]  <= LS;
          ltag[ridx] <= r_addr[1];
          ldat[ridx] <= fill;
          rdata      <= fill;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_done, miss_done;
  assign hit_done  = (st == IDLE) && req && hit;
  assign miss_done = (st == FILL2) ||
                     ((st == MISS_REQ) && gnt && r_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_done && hit_count != 8'hFF)
        hit_count <= hit_count + 8'd1;
      if (miss_done && miss_count != 8'hFF)
        miss_count <= miss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed vector table plus hand sequences
// for victim write-back and grant/intervention collision.
module tb_cache_controller;

  logic       clk = 1'b0;
  logic       rst_n, req, we, bus_grant;
  logic [1:0] addr;
  logic [3:0] wdata, rdata, mem_q;
  logic       done, bus_req;
  logic [7:0] bus_out, snoop;
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .bus_out   (bus_out),
    .snoop     (snoop),
    .mem_q     (mem_q)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic       rn, rq, w;
    logic [1:0] a;
    logic [3:0] wd;
    logic       g;
    logic [7:0] sn;
    logic [3:0] mq;
    logic [7:0] eo;
    logic       ed;
    logic [3:0] er;
    logic       eb;
  } vec_t;

  vec_t tv [$];
  int checks   = 0;
  int failures = 0;

  function automatic void add(
    int rn, int rq, int w, int a, int wd, int g,
    int sn, int mq, int eo, int ed, int er, int eb);
    vec_t v;
    v.rn = 1'(rn); v.rq = 1'(rq); v.w = 1'(w);
    v.a  = 2'(a);  v.wd = 4'(wd); v.g = 1'(g);
    v.sn = 8'(sn); v.mq = 4'(mq);
    v.eo = 8'(eo); v.ed = 1'(ed);
    v.er = 4'(er); v.eb = 1'(eb);
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic rn, input logic rq, input logic w,
    input logic [1:0] a, input logic [3:0] wd,
    input logic g, input logic [7:0] sn,
    input logic [3:0] mq);
    @(negedge clk);
    rst_n = rn; req = rq; we = w; addr = a;
    wdata = wd; bus_grant = g; snoop = sn;
    mem_q = mq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; bus_grant = 1'b0;
    snoop = '0; mem_q = '0;

    //  rn rq w  a wd g  sn    mq    eo    ed er  eb
    add(0, 0, 0, 0, 0, 0, 'h00, 0,   'h00, 0, 0,  0);
    add(1, 0, 0, 0, 0, 0, 'h00, 0,   'h00, 0, 0,  0);
    add(1, 1, 0, 2, 0, 1, 'h00, 0,   'h00, 0, 0,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h60, 0, 0,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 0,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 'hA, 'h00, 1, 'hA, 0);
    add(1, 1, 0, 2, 0, 1, 'h00, 0,   'h00, 1, 'hA, 0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 'hA, 0);
    add(1, 1, 1, 1, 5, 0, 'h00, 0,   'h00, 0, 'hA, 1);
    add(1, 0, 0, 0, 0, 0, 'h00, 0,   'h00, 0, 'hA, 1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h95, 1, 'hA, 0);
    add(1, 1, 0, 3, 0, 1, 'h00, 0,   'h00, 0, 'hA, 1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'hD5, 0, 'hA, 0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 'hA, 1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h70, 0, 'hA, 0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 'hA, 0);
    add(1, 0, 0, 0, 0, 1, 'h00, 3,   'h00, 1, 3,  0);
    add(1, 1, 1, 1, 5, 1, 'h00, 0,   'h00, 0, 3,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h95, 1, 3,  0);
    add(1, 0, 0, 0, 0, 0, 'h50, 0,   'hD5, 0, 3,  0);
    add(1, 0, 0, 0, 0, 0, 'h00, 0,   'h00, 0, 3,  0);
    add(1, 1, 1, 1, 6, 0, 'h00, 0,   'h00, 0, 3,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h96, 1, 3,  0);
    add(1, 0, 0, 0, 0, 0, 'hA0, 0,   'h00, 0, 3,  0);
    add(1, 1, 0, 2, 0, 1, 'h00, 0,   'h00, 0, 3,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h60, 0, 3,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 3,  0);
    add(1, 0, 0, 0, 0, 1, 'hE7, 1,   'h00, 1, 7,  0);
    add(1, 0, 0, 0, 0, 0, 'hA0, 0,   'h00, 0, 7,  0);
    add(1, 1, 0, 2, 0, 1, 'h00, 0,   'h00, 0, 7,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h60, 0, 7,  0);
    add(0, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 0,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 'hA, 'h00, 0, 0,  0);
    add(1, 1, 0, 2, 0, 1, 'h00, 0,   'h00, 0, 0,  1);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h60, 0, 0,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 0,   'h00, 0, 0,  0);
    add(1, 0, 0, 0, 0, 1, 'h00, 9,   'h00, 1, 9,  0);

    foreach (tv[i]) begin
      step(tv[i].rn, tv[i].rq, tv[i].w, tv[i].a,
           tv[i].wd, tv[i].g, tv[i].sn, tv[i].mq);
      chk($sformatf("row%0d bus_out", i),
          bus_out, tv[i].eo);
      chk($sformatf("row%0d done", i),
          {7'd0, done}, {7'd0, tv[i].ed});
      chk($sformatf("row%0d rdata", i),
          {4'd0, rdata}, {4'd0, tv[i].er});
      chk($sformatf("row%0d bus_req", i),
          {7'd0, bus_req}, {7'd0, tv[i].eb});
    end

    // Victim write-back collides with an intervention.
    step(1, 1, 1, 2'd1, 4'h5, 1, 8'h00, 4'h0);
    chk("h1 bus_req", {7'd0, bus_req}, 8'h01);
    step(1, 0, 0, 2'd0, 4'h0, 1, 8'h00, 4'h0);
    chk("h2 bus_out", bus_out, 8'h95);
    chk("h2 done", {7'd0, done}, 8'h01);
    step(1, 1, 1, 2'd3, 4'hC, 1, 8'h00, 4'h0);
    chk("h3 bus_req", {7'd0, bus_req}, 8'h01);
    step(1, 0, 0, 2'd0, 4'h0, 1, 8'h50, 4'h0);
    chk("h4 intervention", bus_out, 8'hD5);
    chk("h4 bus_req held", {7'd0, bus_req}, 8'h01);
    step(1, 0, 0, 2'd0, 4'h0, 1, 8'h00, 4'h0);
    chk("h5 skipped wb", bus_out, 8'h00);
    chk("h5 bus_req", {7'd0, bus_req}, 8'h00);
    step(1, 0, 0, 2'd0, 4'h0, 1, 8'h00, 4'h0);
    chk("h6 bus_req", {7'd0, bus_req}, 8'h01);
    step(1, 0, 0, 2'd0, 4'h0, 1, 8'h00, 4'h0);
    chk("h7 write miss", bus_out, 8'hBC);
    chk("h7 done", {7'd0, done}, 8'h01);
    step(1, 1, 0, 2'd3, 4'h0, 1, 8'h00, 4'h0);
    chk("h8 hit done", {7'd0, done}, 8'h01);
    chk("h8 hit rdata", {4'd0, rdata}, 8'h0C);
    chk("h8 bus_req", {7'd0, bus_req}, 8'h00);
    step(1, 0, 0, 2'd0, 4'h0, 0, 8'h00, 4'h0);
    chk("h9 done pulse", {7'd0, done}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
